// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - decode-side control-flow resolver with return-address stack and fetch redirect
// Optional redirect statistics counter enabled by defining PC_REDIRECT_STATS_EN.
module pc_redirect_unit #(
    parameter int RAS_DEPTH = 4,
    parameter int AW        = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] IF_PC,
    input  logic [AW-1:0] IF_instruction,
    input  logic          instr_valid,
    input  logic          stall,
    input  logic [AW-1:0] rs_val,
    input  logic [AW-1:0] rt_val,
    output logic [1:0]    PCsrc,
    output logic [AW-1:0] I_TypeImmediate,
    output logic [AW-1:0] J_TypeImmediate,
    output logic [AW-1:0] ReturnAddress,
    output logic          flush,
    output logic          ras_underflow,
`ifdef PC_REDIRECT_STATS_EN
    output logic [15:0]   redirect_count,
`endif
    output logic          ras_overflow
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

    typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} state_t;
    state_t state, state_next;

    logic [1:0]    pcsrc_q, pcsrc_next;
    logic [AW-1:0] i_q, j_q, ret_q;
    logic [AW-1:0] ras [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW:0]   count;

    logic [3:0]    op;
    logic          dec, is_beq, is_bne, is_jmp, is_call, is_ret;
    logic          ras_empty, ras_full, operands_eq, taken, push, pop, underflow_hit;
    logic [AW-1:0] i_target, j_target, link_addr;
    logic [PW-1:0] top_idx;

    always_comb begin
        op          = IF_instruction[15:12];
        dec         = instr_valid && !stall && (state == IDLE);
        is_beq      = (op == 4'b1000);
        is_bne      = (op == 4'b1001);
        is_jmp      = (op == 4'b1100);
        is_call     = (op == 4'b1101);
        is_ret      = (op == 4'b1110);
        ras_empty   = (count == '0);
        ras_full    = (count == DEPTH_C);
        operands_eq = (rs_val == rt_val);
        top_idx     = ptr - 1'b1;
        i_target    = IF_PC + {{(AW-6){IF_instruction[5]}}, IF_instruction[5:0]};
        j_target    = {IF_PC[AW-1:12], IF_instruction[11:0]};
        link_addr   = IF_PC + 1'b1;

        push          = dec && is_call;
        pop           = dec && is_ret && !ras_empty;
        underflow_hit = dec && is_ret && ras_empty;
        taken         = dec && (is_jmp || is_call || (is_ret && !ras_empty) ||
                                (is_beq && operands_eq) || (is_bne && !operands_eq));

        pcsrc_next = 2'b00;
        if (is_beq || is_bne)       pcsrc_next = 2'b01;
        else if (is_jmp || is_call) pcsrc_next = 2'b10;
        else if (is_ret)            pcsrc_next = 2'b11;
    end

    always_comb begin
        state_next = state;
        PCsrc      = 2'b00;
        flush      = 1'b0;
        case (state)
            IDLE:     if (taken) state_next = REDIRECT;
            REDIRECT: begin
                PCsrc      = pcsrc_q;
                flush      = 1'b1;
                state_next = SQUASH;
            end
            SQUASH: begin
                flush      = 1'b1;
                state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pcsrc_q       <= 2'b00;
            i_q           <= '0;
            j_q           <= '0;
            ret_q         <= '0;
            ptr           <= '0;
            count         <= '0;
            ras_underflow <= 1'b0;
            ras_overflow  <= 1'b0;
        end else begin
            state         <= state_next;
            ras_underflow <= underflow_hit;
            if (taken) begin
                pcsrc_q <= pcsrc_next;
                if (is_beq || is_bne)       i_q   <= i_target;
                if (is_jmp || is_call)      j_q   <= j_target;
                if (is_ret)                 ret_q <= ras[top_idx];
            end
            // A push while full overwrites the oldest slot: the pointer wraps, count saturates.
            if (push) begin
                ptr <= ptr + 1'b1;
                if (ras_full) ras_overflow <= 1'b1;
                else          count        <= count + 1'b1;
            end else if (pop) begin
                ptr   <= top_idx;
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) ras[ptr] <= link_addr;
    end

`ifdef PC_REDIRECT_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                   redirect_count <= 16'h0000;
        else if (taken && redirect_count != 16'hFFFF)   redirect_count <= redirect_count + 16'h0001;
    end
`endif

    assign I_TypeImmediate = i_q;
    assign J_TypeImmediate = j_q;
    assign ReturnAddress   = ret_q;
endmodule
